bilbo_bist_ctl: RTL and testbench
=================================

BILBO_BIST_CTL -- requirements
Module: bilbo_bist_ctl

Interface
REQ-001 Parameter N, default 8: width of the controlled BILBO register.
REQ-002 Parameter CW, default 16: width of the run-length counter.
REQ-003 Port CLK, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port CLR, input, 1: reset, asynchronous and active-low.
REQ-005 Port START, input, 1: request one BIST sequence; sampled only in IDLE.
REQ-006 Port ABORT, input, 1: terminate the sequence in progress.
REQ-007 Port SEED, input, N: seed value shifted into the register.
REQ-008 Port NCYC, input, CW: number of compaction cycles.
REQ-009 Port GOLDEN, input, N: expected signature.
REQ-010 Port Q, input, N: parallel output of the controlled register.
REQ-011 Port B1, output, 1: BILBO mode bit 1.
REQ-012 Port B2, output, 1: BILBO mode bit 2.
REQ-013 Port SDI, output, 1: serial data into the register.
REQ-014 Port BUSY, output, 1: high in any non-IDLE state.
REQ-015 Port DONE, output, 1: one-cycle pulse when a sequence completes normally.
REQ-016 Port PASS, output, 1: result of the last completed sequence.
REQ-017 Port CNT, output, CW: current run-cycle count.

Function
REQ-018 Mode encoding on {B1,B2}: 11 = normal load, 00 = serial shift, 10 = LFSR/MISR, 01 = clear.
REQ-019 All outputs are registered; no combinational path from any input to any output.
REQ-020 States: IDLE, CLEAR, SEED, RUN, CHECK.
REQ-021 IDLE: {B1,B2}=11, SDI=0, BUSY=0; START=1 and ABORT=0 -> CLEAR.
REQ-022 CLEAR lasts exactly 1 cycle with {B1,B2}=01, then goes to SEED.
REQ-023 SEED lasts exactly N cycles with {B1,B2}=00; SDI carries SEED[N-1] in the first cycle, down to SEED[0] in the last.
REQ-024 SEED, RUN and CHECK use the SEED, NCYC and GOLDEN values captured in the cycle START is accepted; later input changes are ignored until the next START.
REQ-025 After SEED: captured NCYC=0 -> CHECK directly; otherwise -> RUN.
REQ-026 RUN: {B1,B2}=10, SDI=0; CNT starts at 0 and increments each RUN cycle. RUN exits to CHECK after NCYC cycles, when CNT reaches NCYC-1.
REQ-027 CHECK lasts 1 cycle with {B1,B2}=11 held off-load: Q is compared with the captured GOLDEN. PASS <= (Q==GOLDEN), DONE=1 for that cycle, then IDLE.
REQ-028 PASS holds its value until the next CHECK, ABORT, or reset.
REQ-029 CNT holds its final value in IDLE and is zeroed on entry to CLEAR.
REQ-030 ABORT=1 in any non-IDLE state -> IDLE next cycle, with DONE=0, PASS=0 and {B1,B2}=11.
REQ-031 ABORT and START high together in IDLE: ABORT wins and the block stays in IDLE.
REQ-032 START while BUSY=1 is ignored; START is not queued.
REQ-033 NCYC = 2^CW-1 is legal; the counter never wraps within one sequence.

Reset
REQ-034 CLR low immediately forces state IDLE, {B1,B2}=11, SDI=0, BUSY=0, DONE=0, PASS=0, CNT=0, independent of CLK.
REQ-035 Reset asserted mid-sequence discards all progress; the first START after CLR returns high begins a full sequence from CLEAR.

Verification
REQ-036 N=8, SEED=8'hA5, NCYC=3, GOLDEN=Q model value, START pulse -> 1 CLEAR cycle, SDI sequence 1,0,1,0,0,1,0,1, 3 RUN cycles (CNT 0,1,2), DONE at cycle 13 after START, PASS=1.
REQ-037 Same run with GOLDEN differing from Q in bit 0 -> DONE pulse, PASS=0.
REQ-038 NCYC=0 -> SEED is followed directly by CHECK, no cycle has {B1,B2}=10, DONE 10 cycles after START.
REQ-039 ABORT asserted in the 2nd RUN cycle -> IDLE next cycle, no DONE, PASS=0, BUSY=0.
REQ-040 CLR pulsed low mid-SEED -> outputs at reset values without a clock edge; a subsequent START runs the full sequence.
REQ-041 START re-pulsed during RUN, and START+ABORT together in IDLE -> both ignored; sequence timing unchanged.

Source files
------------

// File: rtl/bilbo_bist_ctl_if.sv
// Signal bundle between the BILBO BIST controller and its user.
// The slave modport is the controller; the master drives requests and the register's Q.
interface bilbo_bist_ctl_if #(
  parameter int N  = 8,
  parameter int CW = 16
);
  logic          START;
  logic          ABORT;
  logic [N-1:0]  SEED;
  logic [CW-1:0] NCYC;
  logic [N-1:0]  GOLDEN;
  logic [N-1:0]  Q;
  logic          B1;
  logic          B2;
  logic          SDI;
  logic          BUSY;
  logic          DONE;
  logic          PASS;
  logic [CW-1:0] CNT;

  modport master (
    output START, ABORT, SEED, NCYC, GOLDEN, Q,
    input  B1, B2, SDI, BUSY, DONE, PASS, CNT
  );

  modport slave (
    input  START, ABORT, SEED, NCYC, GOLDEN, Q,
    output B1, B2, SDI, BUSY, DONE, PASS, CNT
  );
endinterface

// File: rtl/bilbo_bist_ctl.sv
// BIST sequencer for a BILBO register: clear, serial seed load, MISR run, signature check.
// Every output is a register updated alongside the state, so outputs describe the current state.
module bilbo_bist_ctl #(
  parameter int N  = 8,
  parameter int CW = 16
) (
  input logic             CLK,
  input logic             CLR,
  bilbo_bist_ctl_if.slave bus
);

  localparam int BW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SEED,
    S_RUN,
    S_CHECK
  } state_t;

  state_t        state_q;
  logic          b1_q;
  logic          b2_q;
  logic          sdi_q;
  logic          busy_q;
  logic          done_q;
  logic          pass_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  seed_q;
  logic [CW-1:0] ncyc_q;
  logic [N-1:0]  golden_q;
  logic [BW-1:0] bit_q;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q  <= S_IDLE;
      b1_q     <= 1'b1;
      b2_q     <= 1'b1;
      sdi_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      cnt_q    <= '0;
      seed_q   <= '0;
      ncyc_q   <= '0;
      golden_q <= '0;
      bit_q    <= '0;
    end else begin
      done_q <= 1'b0;
      sdi_q  <= 1'b0;
      if (state_q != S_IDLE && bus.ABORT) begin
        // CNT is left holding whatever it had reached when the sequence was cut short
        state_q <= S_IDLE;
        b1_q    <= 1'b1;
        b2_q    <= 1'b1;
        busy_q  <= 1'b0;
        pass_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.START && !bus.ABORT) begin
              seed_q   <= bus.SEED;
              ncyc_q   <= bus.NCYC;
              golden_q <= bus.GOLDEN;
              cnt_q    <= '0;
              state_q  <= S_CLEAR;
              b1_q     <= 1'b0;
              b2_q     <= 1'b1;
              busy_q   <= 1'b1;
            end
          end
          S_CLEAR: begin
            state_q <= S_SEED;
            b1_q    <= 1'b0;
            b2_q    <= 1'b0;
            sdi_q   <= seed_q[N-1];
            seed_q  <= seed_q << 1;
            bit_q   <= '0;
          end
          S_SEED: begin
            // The MSB-first shifter is consumed one bit ahead so SDI is ready with the state
            if (bit_q == BW'(N - 1)) begin
              if (ncyc_q == '0) begin
                state_q <= S_CHECK;
                b1_q    <= 1'b1;
                b2_q    <= 1'b1;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_RUN;
                b1_q    <= 1'b1;
                b2_q    <= 1'b0;
              end
            end else begin
              bit_q  <= bit_q + BW'(1);
              sdi_q  <= seed_q[N-1];
              seed_q <= seed_q << 1;
            end
          end
          S_RUN: begin
            if (cnt_q == ncyc_q - CW'(1)) begin
              state_q <= S_CHECK;
              b1_q    <= 1'b1;
              b2_q    <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_CHECK: begin
            pass_q  <= (bus.Q == golden_q);
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            b1_q    <= 1'b1;
            b2_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.B1   = b1_q;
  assign bus.B2   = b2_q;
  assign bus.SDI  = sdi_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.PASS = pass_q;
  assign bus.CNT  = cnt_q;

endmodule

// File: tb/tb_bilbo_bist_ctl.sv
// Bench for bilbo_bist_ctl: table of directed sequences, hand-built reset/IDLE corner cases,
// then randomized sequences, all checked cycle-by-cycle against a timeline model.
module tb_bilbo_bist_ctl;

  localparam int NB  = 8;
  localparam int CWB = 8;

  logic CLK;
  logic CLR;

  bilbo_bist_ctl_if #(.N(NB), .CW(CWB)) bus ();

  bilbo_bist_ctl #(.N(NB), .CW(CWB)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int nvec = 0;
  int nmis = 0;

  logic m_pass;
  int   m_cnt;

  typedef struct {
    logic b1;
    logic b2;
    logic sdi;
    logic busy;
    logic done;
    logic pass;
    int   cnt;
  } exp_t;

  typedef struct {
    logic [NB-1:0] seed;
    int            ncyc;
    logic [NB-1:0] q;
    logic [NB-1:0] golden;
    int            abort_at;
    bit            mess;
    int            exp_done;
    logic          exp_pass;
  } vec_t;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, t, act, exp);
    end
  endtask

  // Run-cycle count visible at cycle t of a sequence (cycle 1 = CLEAR)
  function automatic int cnt_at(input int t, input int nc);
    if (t <= NB + 1) return 0;
    if (t < NB + 2 + nc) return t - (NB + 2);
    return (nc == 0) ? 0 : nc - 1;
  endfunction

  // Timeline: 1 CLEAR, NB SEED cycles, nc RUN cycles, 1 CHECK, then IDLE
  function automatic exp_t model(input int t, input logic [NB-1:0] s, input int nc, input int ab,
                                 input logic pprev, input logic pnew);
    exp_t e;
    int   tchk;
    tchk   = NB + 2 + nc;
    e.b1   = 1'b1;
    e.b2   = 1'b1;
    e.sdi  = 1'b0;
    e.busy = 1'b1;
    e.done = 1'b0;
    e.pass = pprev;
    e.cnt  = cnt_at(t, nc);
    if (ab != 0 && t > ab) begin
      e.busy = 1'b0;
      e.pass = 1'b0;
      e.cnt  = cnt_at(ab, nc);
    end else if (t == 1) begin
      e.b1 = 1'b0;
    end else if (t <= NB + 1) begin
      e.b1  = 1'b0;
      e.b2  = 1'b0;
      e.sdi = s[NB + 1 - t];
    end else if (t < tchk) begin
      e.b2 = 1'b0;
    end else if (t == tchk) begin
      e.done = 1'b1;
    end else begin
      e.busy = 1'b0;
      e.pass = pnew;
    end
    return e;
  endfunction

  task automatic cmp_exp(input int t, input exp_t e);
    chk("B1",   t, bus.B1,   e.b1);
    chk("B2",   t, bus.B2,   e.b2);
    chk("SDI",  t, bus.SDI,  e.sdi);
    chk("BUSY", t, bus.BUSY, e.busy);
    chk("DONE", t, bus.DONE, e.done);
    chk("PASS", t, bus.PASS, e.pass);
    chk("CNT",  t, bus.CNT,  e.cnt);
  endtask

  task automatic idle_check();
    exp_t e;
    step();
    bus.START = 1'b0;
    bus.ABORT = 1'b0;
    e = '{b1: 1'b1, b2: 1'b1, sdi: 1'b0, busy: 1'b0, done: 1'b0, pass: m_pass, cnt: m_cnt};
    cmp_exp(0, e);
  endtask

  task automatic run_seq(input logic [NB-1:0] s, input int nc, input logic [NB-1:0] qv,
                         input logic [NB-1:0] g, input int ab, input bit mess,
                         output int done_at, output logic pass_end);
    int   tchk;
    int   tend;
    logic pnew;
    exp_t e;
    tchk       = NB + 2 + nc;
    tend       = (ab != 0) ? ab + 1 : tchk + 1;
    pnew       = (qv == g);
    bus.SEED   = s;
    bus.NCYC   = CWB'(nc);
    bus.GOLDEN = g;
    bus.Q      = qv;
    bus.ABORT  = 1'b0;
    bus.START  = 1'b1;
    done_at    = 0;
    for (int t = 1; t <= tend; t++) begin
      step();
      bus.START = 1'b0;
      bus.ABORT = 1'b0;
      e = model(t, s, nc, ab, m_pass, pnew);
      cmp_exp(t, e);
      if (bus.DONE === 1'b1) done_at = t;
      if (mess) begin
        bus.SEED   = NB'($urandom);
        bus.NCYC   = CWB'($urandom);
        bus.GOLDEN = NB'($urandom);
        if (t % 4 == 2 && t + 1 < tend) bus.START = 1'b1;
      end
      if (t == ab) bus.ABORT = 1'b1;
    end
    pass_end = bus.PASS;
    m_pass   = (ab != 0) ? 1'b0 : pnew;
    m_cnt    = cnt_at((ab != 0) ? ab : tend, nc);
  endtask

  vec_t          tbl[9];
  int            done_at;
  logic          pass_end;
  logic [NB-1:0] rs, rq, rg, flip;
  int            rnc, rab, rtchk, gaps;
  bit            rmess;
  exp_t          e;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'hA5, 3,   8'h3C, 8'h3C, 0,  1'b0, 13,  1'b1};
    tbl[1] = '{8'hA5, 3,   8'h3C, 8'h3D, 0,  1'b0, 13,  1'b0};
    tbl[2] = '{8'h5A, 0,   8'h77, 8'h77, 0,  1'b0, 10,  1'b1};
    tbl[3] = '{8'hA5, 3,   8'h3C, 8'h3C, 11, 1'b0, 0,   1'b0};
    tbl[4] = '{8'hFF, 1,   8'h00, 8'h00, 0,  1'b0, 11,  1'b1};
    tbl[5] = '{8'h00, 5,   8'h12, 8'h12, 1,  1'b0, 0,   1'b0};
    tbl[6] = '{8'h81, 2,   8'hE4, 8'hE4, 12, 1'b0, 12,  1'b0};
    tbl[7] = '{8'hC3, 255, 8'h9B, 8'h9B, 0,  1'b0, 265, 1'b1};
    tbl[8] = '{8'h01, 4,   8'h6D, 8'h6D, 0,  1'b1, 14,  1'b1};

    bus.START  = 1'b0;
    bus.ABORT  = 1'b0;
    bus.SEED   = '0;
    bus.NCYC   = '0;
    bus.GOLDEN = '0;
    bus.Q      = '0;
    CLR        = 1'b1;
    m_pass     = 1'b0;
    m_cnt      = 0;

    // Reset must act before the first clock edge
    #2 CLR = 1'b0;
    #1;
    e = '{b1: 1'b1, b2: 1'b1, sdi: 1'b0, busy: 1'b0, done: 1'b0, pass: 1'b0, cnt: 0};
    cmp_exp(0, e);
    #9 CLR = 1'b1;
    idle_check();

    for (int i = 0; i < 9; i++) begin
      run_seq(tbl[i].seed, tbl[i].ncyc, tbl[i].q, tbl[i].golden, tbl[i].abort_at, tbl[i].mess,
              done_at, pass_end);
      chk("tbl_done_at", i, done_at, tbl[i].exp_done);
      chk("tbl_pass",    i, pass_end, tbl[i].exp_pass);
      idle_check();
    end

    // START together with ABORT in IDLE is dropped; the next START behaves normally
    run_seq(8'h3C, 2, 8'h11, 8'h11, 0, 1'b0, done_at, pass_end);
    bus.START = 1'b1;
    bus.ABORT = 1'b1;
    idle_check();
    idle_check();
    idle_check();
    run_seq(8'hA5, 3, 8'h3C, 8'h3C, 0, 1'b0, done_at, pass_end);
    chk("start_abort_done_at", 0, done_at, 13);
    chk("start_abort_pass",    0, pass_end, 1'b1);

    // CLR dropped in the middle of SEED, with no clock edge in between
    bus.SEED   = 8'hFF;
    bus.NCYC   = CWB'(3);
    bus.GOLDEN = 8'h3C;
    bus.Q      = 8'h3C;
    bus.START  = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      step();
      bus.START = 1'b0;
      cmp_exp(t, model(t, 8'hFF, 3, 0, m_pass, 1'b1));
    end
    #2 CLR = 1'b0;
    #1;
    e = '{b1: 1'b1, b2: 1'b1, sdi: 1'b0, busy: 1'b0, done: 1'b0, pass: 1'b0, cnt: 0};
    cmp_exp(99, e);
    #1 CLR = 1'b1;
    m_pass = 1'b0;
    m_cnt  = 0;
    idle_check();
    idle_check();
    run_seq(8'hA5, 3, 8'h3C, 8'h3C, 0, 1'b0, done_at, pass_end);
    chk("after_clr_done_at", 0, done_at, 13);
    chk("after_clr_pass",    0, pass_end, 1'b1);
    idle_check();

    for (int k = 0; k < 30; k++) begin
      rs    = NB'($urandom);
      rq    = NB'($urandom);
      rnc   = $urandom_range(0, 12);
      flip  = NB'(1) << $urandom_range(0, NB - 1);
      rg    = ($urandom_range(0, 1) == 1) ? rq : (rq ^ flip);
      rtchk = NB + 2 + rnc;
      rab   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, rtchk) : 0;
      rmess = 1'($urandom_range(0, 1));
      run_seq(rs, rnc, rq, rg, rab, rmess, done_at, pass_end);
      gaps = $urandom_range(0, 2);
      for (int j = 0; j < gaps; j++) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.START = 1'b1;
          bus.ABORT = 1'b1;
        end
        idle_check();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
